// File: rtl/mem_stage_reg_if.sv
// -----------------------------------------------------------------------------
// mem_stage_reg_if
//  Bundles the EX->MEM handshake/bus, the SRAM read-data return and the
//  MEM->WB / MEM->ID outputs of the MEM pipeline stage.
//
//  Signals
//   ex_to_mem_valid  EX holds a completed instruction
//   ex_to_mem_bus    {pc, res_from_mem, rf_we, rf_waddr, alu_result, rkd_value}
//   mem_allowin      MEM can accept from EX this cycle
//   data_sram_rdata  SRAM read data (valid the cycle after EX issued the read)
//   wb_allowin       WB can accept this cycle
//   mem_to_wb_valid  MEM presents an instruction to WB
//   mem_to_wb_bus    {pc, rf_we, rf_waddr, final_result}
//   mem_to_id_bus    {rf_we & valid, rf_waddr, final_result} bypass
//
//  Modports
//   master : environment side (drives EX/SRAM/WB inputs, observes outputs)
//   slave  : the MEM stage itself
// -----------------------------------------------------------------------------
interface mem_stage_reg_if #(
  parameter int DW  = 32,
  parameter int RAW = 5
);
  localparam int EX_BW = 3*DW + 2 + RAW;
  localparam int WB_BW = 2*DW + 1 + RAW;
  localparam int ID_BW = DW + 1 + RAW;

  logic             ex_to_mem_valid;
  logic [EX_BW-1:0] ex_to_mem_bus;
  logic             mem_allowin;
  logic [DW-1:0]    data_sram_rdata;
  logic             wb_allowin;
  logic             mem_to_wb_valid;
  logic [WB_BW-1:0] mem_to_wb_bus;
  logic [ID_BW-1:0] mem_to_id_bus;

  modport master (
    output ex_to_mem_valid, ex_to_mem_bus, data_sram_rdata, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );

  modport slave (
    input  ex_to_mem_valid, ex_to_mem_bus, data_sram_rdata, wb_allowin,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );
endinterface

// File: rtl/mem_stage_reg.sv
// -----------------------------------------------------------------------------
// mem_stage_reg
//  MEM pipeline stage. Latches the EX bus on the valid/allowin handshake,
//  merges the synchronous SRAM read data with the ALU result and forwards the
//  result to WB and to the ID bypass. The SRAM word is only live during the
//  instruction's first MEM cycle, so it is captured into rdata_hold_q and
//  served from there for as long as WB back-pressure keeps the load here.
//
//  Ports
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus_if  mem_stage_reg_if.slave (EX handshake, SRAM rdata, WB/ID outputs)
// -----------------------------------------------------------------------------
module mem_stage_reg #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  mem_stage_reg_if.slave       bus_if
);

  // Read-data source: FIRST = SRAM output is live, HELD = use captured copy.
  typedef enum logic {
    CAP_HELD  = 1'b0,
    CAP_FIRST = 1'b1
  } cap_state_e;

  // EX bus fields
  logic [DW-1:0]  ex_pc;
  logic           ex_res_from_mem;
  logic           ex_rf_we;
  logic [RAW-1:0] ex_rf_waddr;
  logic [DW-1:0]  ex_alu_result;
  logic [DW-1:0]  ex_rkd_value;

  assign {ex_pc, ex_res_from_mem, ex_rf_we, ex_rf_waddr,
          ex_alu_result, ex_rkd_value} = bus_if.ex_to_mem_bus;

  // State
  logic           mem_valid_q,    mem_valid_d;
  logic [DW-1:0]  pc_q,           pc_d;
  logic           res_from_mem_q, res_from_mem_d;
  logic           rf_we_q,        rf_we_d;
  logic [RAW-1:0] rf_waddr_q,     rf_waddr_d;
  logic [DW-1:0]  alu_result_q,   alu_result_d;
  logic [DW-1:0]  rkd_value_q,    rkd_value_d;
  logic [DW-1:0]  rdata_hold_q,   rdata_hold_d;
  cap_state_e     cap_q,          cap_d;

  logic           mem_allowin;
  logic           enter;
  logic [DW-1:0]  load_data;
  logic [DW-1:0]  final_result;
  logic           rf_we_out;
  logic           res_from_mem_out;

  // No internal wait states: ready_go is constantly 1.
  assign mem_allowin = ~mem_valid_q | bus_if.wb_allowin;
  assign enter       = bus_if.ex_to_mem_valid & mem_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q    <= 1'b0;
      pc_q           <= '0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      alu_result_q   <= '0;
      rkd_value_q    <= '0;
      rdata_hold_q   <= '0;
      cap_q          <= CAP_HELD;
    end else begin
      mem_valid_q    <= mem_valid_d;
      pc_q           <= pc_d;
      res_from_mem_q <= res_from_mem_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      alu_result_q   <= alu_result_d;
      rkd_value_q    <= rkd_value_d;
      rdata_hold_q   <= rdata_hold_d;
      cap_q          <= cap_d;
    end
  end

  always_comb begin
    mem_valid_d    = mem_valid_q;
    pc_d           = pc_q;
    res_from_mem_d = res_from_mem_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    alu_result_d   = alu_result_q;
    rkd_value_d    = rkd_value_q;
    rdata_hold_d   = rdata_hold_q;
    cap_d          = CAP_HELD;

    if (mem_allowin) begin
      mem_valid_d = bus_if.ex_to_mem_valid;
    end

    // A bubble keeps the stale payload; mem_valid_q masks its enables.
    if (enter) begin
      pc_d           = ex_pc;
      res_from_mem_d = ex_res_from_mem;
      rf_we_d        = ex_rf_we;
      rf_waddr_d     = ex_rf_waddr;
      alu_result_d   = ex_alu_result;
      rkd_value_d    = ex_rkd_value;
    end

    // Capture on every FIRST-cycle edge, even when the instruction leaves,
    // so a stall that follows always finds the word in rdata_hold_q.
    case (cap_q)
      CAP_FIRST: rdata_hold_d = bus_if.data_sram_rdata;
      default:   rdata_hold_d = rdata_hold_q;
    endcase

    // A newly entering instruction always starts in FIRST, including the
    // leave+enter case; otherwise the stage falls (or stays) in HELD.
    if (enter) begin
      cap_d = CAP_FIRST;
    end
  end

  assign load_data        = (cap_q == CAP_FIRST) ? bus_if.data_sram_rdata : rdata_hold_q;
  assign rf_we_out        = rf_we_q & mem_valid_q;
  assign res_from_mem_out = res_from_mem_q & mem_valid_q;
  assign final_result     = res_from_mem_out ? load_data : alu_result_q;

  assign bus_if.mem_allowin     = mem_allowin;
  assign bus_if.mem_to_wb_valid = mem_valid_q;
  assign bus_if.mem_to_wb_bus   = {pc_q, rf_we_out, rf_waddr_q, final_result};
  assign bus_if.mem_to_id_bus   = {rf_we_out, rf_waddr_q, final_result};

  // rkd_value travels with the instruction but has no consumer in this stage.
  logic rkd_unused;
  assign rkd_unused = ^rkd_value_q;

endmodule
